// File: rtl/ascon_masked_seq.sv
// Sequencer between the CW305 register block and a masked Ascon core:
// issues one core operation per accepted start, captures shared output
// words into a small buffer, serves recombined/raw-share readback, and
// produces a scope trigger window plus watchdog/short/overflow flags.
module ascon_masked_seq #(
  parameter int unsigned pCORE_WIDTH = 64,
  parameter int unsigned pSHARES     = 2,
  parameter int unsigned pRND_WIDTH  = 320,
  parameter int unsigned pOUT_DEPTH  = 8,
  parameter int unsigned pTIMEOUT    = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 init,
  input  logic                                 start,
  input  logic [1:0]                           cfg_mode,
  input  logic [$clog2(pOUT_DEPTH):0]          cfg_nwords,
  input  logic [7:0]                           cfg_trig_dly,
  input  logic [7:0]                           cfg_trig_len,
  input  logic [pSHARES*pCORE_WIDTH-1:0]       sdin,
  input  logic [pRND_WIDTH-1:0]                rdin,
  output logic                                 core_start,
  output logic [1:0]                           core_mode,
  output logic [pSHARES*pCORE_WIDTH-1:0]       core_sdin,
  output logic [pRND_WIDTH-1:0]                core_rdin,
  input  logic [pSHARES*pCORE_WIDTH-1:0]       core_dout,
  input  logic                                 core_dout_valid,
  input  logic                                 core_done,
  input  logic [$clog2(pOUT_DEPTH)-1:0]        raddr,
  input  logic                                 rd_unmask,
  input  logic [1:0]                           rd_share,
  output logic [pCORE_WIDTH-1:0]               dout,
  output logic [$clog2(pOUT_DEPTH):0]          wcount,
  output logic                                 busy,
  output logic                                 trigger,
  output logic [2:0]                           flags
);

  localparam int unsigned AW = $clog2(pOUT_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned SW = pSHARES * pCORE_WIDTH;
  localparam int unsigned TW = $clog2(pTIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]             state_q,      state_d;
  logic                   core_start_q, core_start_d;
  logic [1:0]             core_mode_q,  core_mode_d;
  logic [NW-1:0]          wptr_q,       wptr_d;
  logic [NW-1:0]          nwords_q,     nwords_d;
  logic [TW-1:0]          wd_q,         wd_d;
  logic [8:0]             trig_cnt_q,   trig_cnt_d;
  logic [7:0]             dly_q,        dly_d;
  logic [7:0]             len_q,        len_d;
  logic [2:0]             flags_q,      flags_d;
  logic [pCORE_WIDTH-1:0] dout_q,       dout_d;

  logic [SW-1:0]          mem_q [pOUT_DEPTH];
  logic                   mem_we;
  logic [SW-1:0]          rd_word;
  logic                   accept;

  assign core_sdin  = sdin;
  assign core_rdin  = rdin;
  assign core_start = core_start_q;
  assign core_mode  = core_mode_q;
  assign wcount     = wptr_q;
  assign busy       = (state_q == S_RUN);
  assign flags      = flags_q;
  assign dout       = dout_q;
  // Window is gated by RUN so leaving RUN truncates it; the 9-bit sum cannot wrap.
  assign trigger    = (state_q == S_RUN) && (len_q != 8'd0) &&
                      (trig_cnt_q > {1'b0, dly_q}) &&
                      (trig_cnt_q <= ({1'b0, dly_q} + {1'b0, len_q}));

  // Control next-state: init beats start, start beats run-time events.
  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    core_mode_d  = core_mode_q;
    wptr_d       = wptr_q;
    nwords_d     = nwords_q;
    wd_d         = wd_q;
    trig_cnt_d   = trig_cnt_q;
    dly_d        = dly_q;
    len_d        = len_q;
    flags_d      = flags_q;
    mem_we       = 1'b0;
    accept       = start && !init && (cfg_nwords != '0) &&
                   (cfg_nwords <= NW'(pOUT_DEPTH)) && (cfg_mode != 2'd3) &&
                   (state_q != S_RUN);
    if (init) begin
      state_d = S_IDLE;
      wptr_d  = '0;
      flags_d = '0;
    end else if (accept) begin
      state_d      = S_RUN;
      core_start_d = 1'b1;
      core_mode_d  = cfg_mode;
      wptr_d       = '0;
      nwords_d     = cfg_nwords;
      wd_d         = '0;
      trig_cnt_d   = '0;
      dly_d        = cfg_trig_dly;
      len_d        = cfg_trig_len;
      flags_d      = '0;
    end else if (state_q == S_RUN) begin
      wd_d = wd_q + 1'b1;
      if (trig_cnt_q != '1) trig_cnt_d = trig_cnt_q + 1'b1;
      if (core_dout_valid) begin
        if (wptr_q < nwords_q) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end else begin
          flags_d[0] = 1'b1;
        end
      end
      // Short check uses wptr_d so a word arriving with done is counted.
      if (core_done) begin
        state_d = S_IDLE;
        if (wptr_d < nwords_q) flags_d[1] = 1'b1;
      end else if (wd_q == TW'(pTIMEOUT - 1)) begin
        state_d    = S_ERR;
        flags_d[2] = 1'b1;
      end
    end
  end

  // Registered readback: recombine all shares or select one raw share.
  always_comb begin
    rd_word = mem_q[raddr];
    dout_d  = '0;
    if (rd_unmask) begin
      for (int unsigned i = 0; i < pSHARES; i++)
        dout_d = dout_d ^ rd_word[i*pCORE_WIDTH +: pCORE_WIDTH];
    end else begin
      for (int unsigned i = 0; i < pSHARES; i++)
        if (32'(rd_share) == i) dout_d = rd_word[i*pCORE_WIDTH +: pCORE_WIDTH];
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      core_start_q <= 1'b0;
      core_mode_q  <= '0;
      wptr_q       <= '0;
      nwords_q     <= '0;
      wd_q         <= '0;
      trig_cnt_q   <= '0;
      dly_q        <= '0;
      len_q        <= '0;
      flags_q      <= '0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      core_mode_q  <= core_mode_d;
      wptr_q       <= wptr_d;
      nwords_q     <= nwords_d;
      wd_q         <= wd_d;
      trig_cnt_q   <= trig_cnt_d;
      dly_q        <= dly_d;
      len_q        <= len_d;
      flags_q      <= flags_d;
      dout_q       <= dout_d;
    end
  end

  // Capture buffer; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wptr_q[AW-1:0]] <= core_dout;
  end

endmodule

// File: tb/tb_ascon_masked_seq.sv
// Self-checking bench for ascon_masked_seq with a read scoreboard and a
// small capture model of the output buffer.
module tb_ascon_masked_seq;

  localparam int unsigned W   = 64;
  localparam int unsigned SH  = 2;
  localparam int unsigned SW  = W * SH;
  localparam int unsigned RW  = 320;
  localparam int unsigned DEP = 8;
  localparam int unsigned TO  = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0, start = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [3:0]    cfg_nwords = '0;
  logic [7:0]    cfg_trig_dly = '0, cfg_trig_len = '0;
  logic [SW-1:0] sdin = '0;
  logic [RW-1:0] rdin = '0;
  logic          core_start;
  logic [1:0]    core_mode;
  logic [SW-1:0] core_sdin;
  logic [RW-1:0] core_rdin;
  logic [SW-1:0] core_dout = '0;
  logic          core_dout_valid = 1'b0, core_done = 1'b0;
  logic [2:0]    raddr = '0;
  logic          rd_unmask = 1'b0;
  logic [1:0]    rd_share = '0;
  logic [W-1:0]  dout;
  logic [3:0]    wcount;
  logic          busy, trigger;
  logic [2:0]    flags;

  int n_chk = 0;
  int n_err = 0;

  logic [SW-1:0] exp_m [DEP];
  int            tb_wptr = 0, tb_nw = 0;
  bit            tb_run = 0;
  logic [W-1:0]  rd_q [$];

  ascon_masked_seq #(
    .pCORE_WIDTH(W), .pSHARES(SH), .pRND_WIDTH(RW), .pOUT_DEPTH(DEP), .pTIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .start(start), .cfg_mode(cfg_mode),
    .cfg_nwords(cfg_nwords), .cfg_trig_dly(cfg_trig_dly), .cfg_trig_len(cfg_trig_len),
    .sdin(sdin), .rdin(rdin), .core_start(core_start), .core_mode(core_mode),
    .core_sdin(core_sdin), .core_rdin(core_rdin), .core_dout(core_dout),
    .core_dout_valid(core_dout_valid), .core_done(core_done), .raddr(raddr),
    .rd_unmask(rd_unmask), .rd_share(rd_share), .dout(dout), .wcount(wcount),
    .busy(busy), .trigger(trigger), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [319:0] act, input logic [319:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] mode, input int nw, input int dly, input int len);
    cfg_mode = mode; cfg_nwords = 4'(nw);
    cfg_trig_dly = 8'(dly); cfg_trig_len = 8'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("core_start_on_accept", core_start, 1);
    check("busy_on_accept", busy, 1);
    check("core_mode_latched", core_mode, mode);
    tb_run = 1; tb_wptr = 0; tb_nw = nw;
  endtask

  task automatic send(input logic [SW-1:0] w, input bit done);
    core_dout = w; core_dout_valid = 1'b1; core_done = done;
    tick();
    core_dout_valid = 1'b0; core_done = 1'b0;
    if (tb_run) begin
      if (tb_wptr < tb_nw) begin
        exp_m[tb_wptr] = w;
        tb_wptr++;
      end
      if (done) tb_run = 0;
    end
  endtask

  task automatic rd(input int a, input bit unm, input int sh, input logic [W-1:0] exp);
    raddr = 3'(a); rd_unmask = unm; rd_share = 2'(sh);
    rd_q.push_back(exp);
    tick();
    check($sformatf("read_a%0d_u%0d_s%0d", a, unm, sh), dout, rd_q.pop_front());
  endtask

  function automatic logic [W-1:0] unmask(input logic [SW-1:0] w);
    return w[W-1:0] ^ w[SW-1:W];
  endfunction

  localparam logic [W-1:0] A = 64'h0123_4567_89ab_cdef;
  localparam logic [W-1:0] B = 64'hfeed_face_cafe_beef;
  localparam logic [W-1:0] M = 64'h5a5a_1234_a5a5_9876;
  localparam logic [W-1:0] N = 64'h0f0f_f0f0_3c3c_c3c3;

  initial begin
    logic [SW-1:0] x0, x1, x2;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_trigger", trigger, 0);
    check("rst_flags", flags, 0);
    check("rst_wcount", wcount, 0);
    check("rst_dout", dout, 0);
    rst = 1'b1;
    tick();

    sdin = {$urandom, $urandom, $urandom, $urandom};
    rdin = {10{$urandom}};
    #1;
    check("sdin_pass", core_sdin, sdin);
    check("rdin_pass", core_rdin, rdin);

    // Basic two-word operation
    do_start(2'd0, 2, 0, 0);
    send({M, A ^ M}, 0);
    core_dout = {N, B ^ N}; core_dout_valid = 1'b1; core_done = 1'b1;
    check("busy_in_done_cycle", busy, 1);
    tick();
    core_dout_valid = 1'b0; core_done = 1'b0; tb_run = 0;
    exp_m[0] = {M, A ^ M}; exp_m[1] = {N, B ^ N}; tb_wptr = 2;
    check("t1_busy_after_done", busy, 0);
    check("t1_wcount", wcount, 2);
    check("t1_flags", flags, 3'b000);
    rd(0, 1, 0, A);
    rd(1, 1, 0, B);
    rd(0, 0, 1, M);
    rd(0, 0, 0, A ^ M);
    rd(1, 0, 2, '0);

    // Overflow: three words into a one-word operation
    x0 = {$urandom, $urandom, $urandom, $urandom};
    x1 = {$urandom, $urandom, $urandom, $urandom};
    x2 = {$urandom, $urandom, $urandom, $urandom};
    do_start(2'd1, 1, 0, 0);
    send(x0, 0); send(x1, 0); send(x2, 0);
    send('0, 0);
    core_done = 1'b1; tick(); core_done = 1'b0; tb_run = 0;
    check("t2_flags_overflow", flags, 3'b001);
    check("t2_wcount", wcount, 1);
    rd(0, 1, 0, unmask(exp_m[0]));
    rd(1, 1, 0, B);

    // Short: one word then done with nwords=4
    do_start(2'd2, 4, 0, 0);
    send(x2, 1);
    check("t3_flags_short", flags, 3'b010);
    check("t3_wcount", wcount, 4'(tb_wptr));
    check("t3_idle", busy, 0);
    rd(0, 1, 0, unmask(exp_m[0]));

    // Watchdog timeout
    do_start(2'd0, 2, 0, 0);
    repeat (TO - 1) tick();
    check("t4_busy_before_timeout", busy, 1);
    tick();
    tb_run = 0;
    check("t4_busy_timeout", busy, 0);
    check("t4_flags_timeout", flags, 3'b100);
    send(x1, 1);
    check("t4_err_ignores_done", flags, 3'b100);
    check("t4_err_no_capture", wcount, 0);
    do_start(2'd0, 2, 0, 0);
    check("t4_flags_cleared", flags, 3'b000);
    send(x1, 0); send(x0, 1);
    check("t4_wcount", wcount, 2);
    rd(1, 1, 0, unmask(exp_m[1]));

    // Trigger window dly=3 len=5, done at count 6
    do_start(2'd0, 4, 3, 5);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t5_trig_c%0d", c), trigger, (c >= 4 && c <= 6));
      if (c == 6) send(x0, 1); else tick();
    end
    do_start(2'd0, 4, 3, 0);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("t5_trig_len0_c%0d", c), trigger, 0);
      tick();
    end
    send(x0, 1);

    // init mid-RUN
    do_start(2'd0, 2, 0, 0);
    send(x1, 0);
    init = 1'b1; tick(); init = 1'b0; tb_run = 0;
    check("t6_init_busy", busy, 0);
    check("t6_init_wcount", wcount, 0);
    check("t6_init_flags", flags, 3'b000);
    send(x2, 0);
    check("t6_no_capture_after_init", wcount, 0);
    rd(0, 1, 0, unmask(exp_m[0]));

    // start together with init
    cfg_mode = 2'd0; cfg_nwords = 4'd2; start = 1'b1; init = 1'b1;
    tick();
    start = 1'b0; init = 1'b0;
    check("t7_init_wins_start", core_start, 0);
    check("t7_init_wins_busy", busy, 0);

    // Rejected starts leave flags alone
    do_start(2'd0, 4, 0, 0);
    send(x0, 1);
    check("t8_short_before_reject", flags, 3'b010);
    foreach (cfg_nwords[i]) ;
    for (int k = 0; k < 3; k++) begin
      cfg_mode   = (k == 0) ? 2'd3 : 2'd0;
      cfg_nwords = (k == 1) ? 4'd0 : ((k == 2) ? 4'd9 : 4'd2);
      start = 1'b1; tick(); start = 1'b0;
      check($sformatf("t8_reject%0d_core_start", k), core_start, 0);
      check($sformatf("t8_reject%0d_busy", k), busy, 0);
      check($sformatf("t8_reject%0d_flags", k), flags, 3'b010);
    end

    // Asynchronous reset mid-RUN
    raddr = 3'd0; rd_unmask = 1'b1;
    do_start(2'd2, 4, 0, 5);
    send(x1, 0);
    check("t9_trigger_before_rst", trigger, 1);
    check("t9_wcount_before_rst", wcount, 1);
    #2 rst = 1'b0;
    #1;
    check("t9_rst_busy", busy, 0);
    check("t9_rst_trigger", trigger, 0);
    check("t9_rst_core_mode", core_mode, 0);
    check("t9_rst_wcount", wcount, 0);
    check("t9_rst_flags", flags, 0);
    check("t9_rst_dout", dout, 0);
    check("t9_rst_core_start", core_start, 0);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
